// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester byte-serial SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L0A,
        L0B,
        L1A,
        L1B
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_VID = 1'b0;
    localparam req_id_t REQ_CPU = 1'b1;

    localparam int MAX_VID_RUN_DEF = 4;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection between video and CPU, with the saturating video-run
// counter that bounds how long the CPU can be starved.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int MAX_VID_RUN = MAX_VID_RUN_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    arb_en,
    input  logic    vid_req,
    input  logic    cpu_req,
    output logic    gnt_vid,
    output logic    gnt_cpu,
    output req_id_t winner
);

    localparam int               RUN_W   = $clog2(MAX_VID_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VID_RUN);

    logic [RUN_W-1:0] vid_run_q;
    logic [RUN_W-1:0] vid_run_d;
    logic             cpu_wins;

    always_comb begin
        // NOTE: vid_run_d gets its hold value first so no branch can infer a latch.
        vid_run_d = vid_run_q;
        cpu_wins  = cpu_req && (!vid_req || (vid_run_q == RUN_MAX));
        gnt_cpu   = arb_en && cpu_wins;
        gnt_vid   = arb_en && vid_req && !cpu_wins;
        winner    = cpu_wins ? REQ_CPU : REQ_VID;

        if (gnt_cpu) begin
            vid_run_d = '0;
        end else if (gnt_vid && (vid_run_q != RUN_MAX)) begin
            vid_run_d = vid_run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every flop samples pre-edge values whatever the statement order.
        if (!rst_n) begin
            vid_run_q <= '0;
        end else begin
            vid_run_q <= vid_run_d;
        end
    end

endmodule

// File: rtl/sram_word_arbiter.sv
// Shares one 8-bit async SRAM between video and CPU word requesters; every
// granted word is two fixed-length byte cycles, even byte first.
module sram_word_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int MAX_VID_RUN = MAX_VID_RUN_DEF
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic              VID_GNT,
    output logic              VID_DONE,
    output logic [15:0]       VID_RDATA,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [1:0]        CPU_BE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [15:0]       CPU_WDATA,
    output logic              CPU_GNT,
    output logic              CPU_DONE,
    output logic [15:0]       CPU_RDATA,
    output logic [ADDR_W:0]   SRAM_ADDR,
    output logic              SRAM_WE_n,
    output logic [7:0]        SRAM_DQ_O,
    output logic              SRAM_DQ_OE,
    input  logic [7:0]        SRAM_DQ_I
);

    arb_state_e        state_q, state_d;
    req_id_t           owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        be_q, be_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [7:0]        byte0_q, byte0_d;

    logic [ADDR_W:0]   sram_addr_q, sram_addr_d;
    logic              sram_we_n_q, sram_we_n_d;
    logic [7:0]        sram_dq_o_q, sram_dq_o_d;
    logic              sram_dq_oe_q, sram_dq_oe_d;

    logic              vid_gnt_q, vid_gnt_d;
    logic              vid_done_q, vid_done_d;
    logic [15:0]       vid_rdata_q, vid_rdata_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              cpu_done_q, cpu_done_d;
    logic [15:0]       cpu_rdata_q, cpu_rdata_d;

    logic              arb_en;
    logic              gnt_vid;
    logic              gnt_cpu;
    req_id_t           winner;

    assign arb_en = (state_q == IDLE) || (state_q == L1B);

    sram_arb_pick #(
        .MAX_VID_RUN(MAX_VID_RUN)
    ) u_pick (
        .clk    (CLK),
        .rst_n  (RST_n),
        .arb_en (arb_en),
        .vid_req(VID_REQ),
        .cpu_req(CPU_REQ),
        .gnt_vid(gnt_vid),
        .gnt_cpu(gnt_cpu),
        .winner (winner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        byte0_d      = byte0_q;
        sram_addr_d  = sram_addr_q;
        sram_we_n_d  = 1'b1;
        sram_dq_o_d  = sram_dq_o_q;
        sram_dq_oe_d = sram_dq_oe_q;
        vid_gnt_d    = 1'b0;
        vid_done_d   = 1'b0;
        vid_rdata_d  = vid_rdata_q;
        cpu_gnt_d    = 1'b0;
        cpu_done_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;

        case (state_q)
            L0A: begin
                state_d     = L0B;
                sram_we_n_d = ~(we_q & be_q[0]);
            end
            L0B: begin
                state_d      = L1A;
                byte0_d      = SRAM_DQ_I;
                sram_addr_d  = {addr_q, 1'b1};
                sram_dq_o_d  = wdata_q[15:8];
                sram_dq_oe_d = we_q & be_q[1];
            end
            L1A: begin
                state_d     = L1B;
                sram_we_n_d = ~(we_q & be_q[1]);
            end
            default: begin
                // IDLE and L1B: finish the current word, then arbitrate.
                if (state_q == L1B) begin
                    if (owner_q == REQ_CPU) begin
                        cpu_done_d  = 1'b1;
                        cpu_rdata_d = {SRAM_DQ_I, byte0_q};
                    end else begin
                        vid_done_d  = 1'b1;
                        vid_rdata_d = {SRAM_DQ_I, byte0_q};
                    end
                end

                state_d      = IDLE;
                sram_dq_oe_d = 1'b0;

                if (gnt_vid || gnt_cpu) begin
                    state_d      = L0A;
                    owner_d      = winner;
                    addr_d       = gnt_cpu ? CPU_ADDR : VID_ADDR;
                    we_d         = gnt_cpu & CPU_WE;
                    be_d         = gnt_cpu ? CPU_BE : 2'b11;
                    wdata_d      = gnt_cpu ? CPU_WDATA : 16'h0000;
                    sram_addr_d  = {addr_d, 1'b0};
                    sram_dq_o_d  = wdata_d[7:0];
                    sram_dq_oe_d = we_d & be_d[0];
                    vid_gnt_d    = gnt_vid;
                    cpu_gnt_d    = gnt_cpu;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            // NOTE: datapath latches are reset too so nothing undefined reaches the pins.
            state_q      <= IDLE;
            owner_q      <= REQ_VID;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= 2'b00;
            wdata_q      <= 16'h0000;
            byte0_q      <= 8'h00;
            sram_addr_q  <= '0;
            sram_we_n_q  <= 1'b1;
            sram_dq_o_q  <= 8'h00;
            sram_dq_oe_q <= 1'b0;
            vid_gnt_q    <= 1'b0;
            vid_done_q   <= 1'b0;
            vid_rdata_q  <= 16'h0000;
            cpu_gnt_q    <= 1'b0;
            cpu_done_q   <= 1'b0;
            cpu_rdata_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            byte0_q      <= byte0_d;
            sram_addr_q  <= sram_addr_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_dq_o_q  <= sram_dq_o_d;
            sram_dq_oe_q <= sram_dq_oe_d;
            vid_gnt_q    <= vid_gnt_d;
            vid_done_q   <= vid_done_d;
            vid_rdata_q  <= vid_rdata_d;
            cpu_gnt_q    <= cpu_gnt_d;
            cpu_done_q   <= cpu_done_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign SRAM_ADDR  = sram_addr_q;
    assign SRAM_WE_n  = sram_we_n_q;
    assign SRAM_DQ_O  = sram_dq_o_q;
    assign SRAM_DQ_OE = sram_dq_oe_q;
    assign VID_GNT    = vid_gnt_q;
    assign VID_DONE   = vid_done_q;
    assign VID_RDATA  = vid_rdata_q;
    assign CPU_GNT    = cpu_gnt_q;
    assign CPU_DONE   = cpu_done_q;
    assign CPU_RDATA  = cpu_rdata_q;

endmodule

// File: tb/tb_sram_word_arbiter.sv
// Directed bench for sram_word_arbiter: byte-wide SRAM model, a reference
// memory for expected read data and per-requester completion scoreboards.
module tb_sram_word_arbiter;

    localparam int ADDR_W = 20;

    logic              CLK = 1'b0;
    logic              RST_n = 1'b0;
    logic              VID_REQ;
    logic [ADDR_W-1:0] VID_ADDR;
    logic              VID_GNT, VID_DONE;
    logic [15:0]       VID_RDATA;
    logic              CPU_REQ, CPU_WE;
    logic [1:0]        CPU_BE;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [15:0]       CPU_WDATA;
    logic              CPU_GNT, CPU_DONE;
    logic [15:0]       CPU_RDATA;
    logic [ADDR_W:0]   SRAM_ADDR;
    logic              SRAM_WE_n;
    logic [7:0]        SRAM_DQ_O;
    logic              SRAM_DQ_OE;
    logic [7:0]        SRAM_DQ_I;

    always #5 CLK = ~CLK;

    sram_word_arbiter #(
        .ADDR_W     (ADDR_W),
        .MAX_VID_RUN(4)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .VID_REQ   (VID_REQ),
        .VID_ADDR  (VID_ADDR),
        .VID_GNT   (VID_GNT),
        .VID_DONE  (VID_DONE),
        .VID_RDATA (VID_RDATA),
        .CPU_REQ   (CPU_REQ),
        .CPU_WE    (CPU_WE),
        .CPU_BE    (CPU_BE),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_WDATA (CPU_WDATA),
        .CPU_GNT   (CPU_GNT),
        .CPU_DONE  (CPU_DONE),
        .CPU_RDATA (CPU_RDATA),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_n (SRAM_WE_n),
        .SRAM_DQ_O (SRAM_DQ_O),
        .SRAM_DQ_OE(SRAM_DQ_OE),
        .SRAM_DQ_I (SRAM_DQ_I)
    );

    typedef struct {
        logic        chk;
        logic [15:0] data;
    } exp_t;

    exp_t       vid_sb[$];
    exp_t       cpu_sb[$];
    int         vid_gc[$];
    int         cpu_gc[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    // SRAM model: low address bits only; write lands at the end of a low-strobe cycle.
    assign SRAM_DQ_I = mem[SRAM_ADDR[7:0]];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST_n && !SRAM_WE_n) begin
            check("oe_during_strobe", SRAM_DQ_OE, 1);
            mem[SRAM_ADDR[7:0]] <= SRAM_DQ_O;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [ADDR_W-1:0] a);
        logic [7:0] i;
        i = {a[6:0], 1'b0};
        return {ref_mem[i | 8'd1], ref_mem[i]};
    endfunction

    task automatic check_done(input bit is_cpu, input logic [15:0] rd);
        exp_t e;
        int   g;
        if (is_cpu) begin
            check("cpu_done_expected", (cpu_sb.size() > 0) && (cpu_gc.size() > 0), 1);
            if (cpu_sb.size() > 0 && cpu_gc.size() > 0) begin
                e = cpu_sb.pop_front();
                g = cpu_gc.pop_front();
                check("cpu_gnt_to_done", cyc - g, 4);
                if (e.chk) check("cpu_rdata", rd, e.data);
            end
        end else begin
            check("vid_done_expected", (vid_sb.size() > 0) && (vid_gc.size() > 0), 1);
            if (vid_sb.size() > 0 && vid_gc.size() > 0) begin
                e = vid_sb.pop_front();
                g = vid_gc.pop_front();
                check("vid_gnt_to_done", cyc - g, 4);
                if (e.chk) check("vid_rdata", rd, e.data);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RST_n) begin
            if (VID_GNT) vid_gc.push_back(cyc);
            if (CPU_GNT) cpu_gc.push_back(cyc);
            if (VID_DONE) check_done(1'b0, VID_RDATA);
            if (CPU_DONE) check_done(1'b1, CPU_RDATA);
        end
    end

    task automatic wait_gnt(input bit cpu, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (cpu ? CPU_GNT : VID_GNT) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (vid_sb.size() == 0 && cpu_sb.size() == 0) break;
            @(negedge CLK);
        end
        check("drain_timeout", vid_sb.size() + cpu_sb.size(), 0);
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_we_n"}, SRAM_WE_n, 1);
        check({tag, "_oe"}, SRAM_DQ_OE, 0);
        check({tag, "_addr"}, SRAM_ADDR, 0);
        check({tag, "_dq_o"}, SRAM_DQ_O, 0);
        check({tag, "_gnts"}, {VID_GNT, CPU_GNT}, 0);
        check({tag, "_dones"}, {VID_DONE, CPU_DONE}, 0);
        check({tag, "_vid_rdata"}, VID_RDATA, 0);
        check({tag, "_cpu_rdata"}, CPU_RDATA, 0);
    endtask

    task automatic cpu_write_pins(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                                  input logic [1:0] be);
        bit         ok;
        logic [7:0] i;
        i = {a[6:0], 1'b0};
        if (be[0]) ref_mem[i] = d[7:0];
        if (be[1]) ref_mem[i | 8'd1] = d[15:8];
        cpu_sb.push_back('{1'b0, 16'h0000});
        CPU_ADDR = a; CPU_WE = 1'b1; CPU_BE = be; CPU_WDATA = d; CPU_REQ = 1'b1;
        wait_gnt(1'b1, ok);
        check("wr_gnt_seen", ok, 1);
        CPU_REQ = 1'b0; CPU_WDATA = ~d; CPU_ADDR = a ^ 20'h1; CPU_BE = ~be;
        if (!ok) return;
        check("wr_l0a_addr", SRAM_ADDR, {a, 1'b0});
        check("wr_l0a_we_n", SRAM_WE_n, 1);
        check("wr_l0a_oe", SRAM_DQ_OE, be[0]);
        if (be[0]) check("wr_l0a_dq", SRAM_DQ_O, d[7:0]);
        @(negedge CLK);
        check("wr_l0b_addr", SRAM_ADDR, {a, 1'b0});
        check("wr_l0b_we_n", SRAM_WE_n, !be[0]);
        check("wr_l0b_oe", SRAM_DQ_OE, be[0]);
        if (be[0]) check("wr_l0b_dq", SRAM_DQ_O, d[7:0]);
        @(negedge CLK);
        check("wr_l1a_addr", SRAM_ADDR, {a, 1'b1});
        check("wr_l1a_we_n", SRAM_WE_n, 1);
        check("wr_l1a_oe", SRAM_DQ_OE, be[1]);
        if (be[1]) check("wr_l1a_dq", SRAM_DQ_O, d[15:8]);
        @(negedge CLK);
        check("wr_l1b_addr", SRAM_ADDR, {a, 1'b1});
        check("wr_l1b_we_n", SRAM_WE_n, !be[1]);
        check("wr_l1b_done_early", CPU_DONE, 0);
        @(negedge CLK);
        check("wr_done_at_e4", CPU_DONE, 1);
        check("wr_idle_we_n", SRAM_WE_n, 1);
    endtask

    task automatic vid_read(input logic [ADDR_W-1:0] a);
        bit ok;
        vid_sb.push_back('{1'b1, exp_word(a)});
        VID_ADDR = a; VID_REQ = 1'b1;
        wait_gnt(1'b0, ok);
        check("vid_gnt_seen", ok, 1);
        VID_REQ = 1'b0; VID_ADDR = ~a;
        if (ok) check("vid_l0a_oe", SRAM_DQ_OE, 0);
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a);
        bit ok;
        cpu_sb.push_back('{1'b1, exp_word(a)});
        CPU_ADDR = a; CPU_WE = 1'b0; CPU_BE = 2'b11; CPU_REQ = 1'b1;
        wait_gnt(1'b1, ok);
        check("rd_gnt_seen", ok, 1);
        CPU_REQ = 1'b0; CPU_ADDR = ~a; CPU_WE = 1'b1;
    endtask

    initial begin
        bit         ok, got;
        logic [9:0] order;
        int         last;

        VID_REQ = 1'b0; VID_ADDR = '0;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_BE = 2'b00; CPU_ADDR = '0; CPU_WDATA = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end

        repeat (3) @(negedge CLK);
        check_rst("por");
        RST_n = 1'b1;
        @(negedge CLK);

        // Full write, then read it back through the video port.
        cpu_write_pins(20'h00012, 16'hBEEF, 2'b11);
        vid_read(20'h00012);
        drain();
        check("vid_rdata_beef", VID_RDATA, 16'hBEEF);

        // Odd byte only: lane 0 keeps its strobe high and its bus undriven.
        cpu_write_pins(20'h00012, 16'h1234, 2'b10);
        check("vid_rdata_hold", VID_RDATA, 16'hBEEF);
        vid_read(20'h00012);
        cpu_read(20'h00012);
        drain();
        check("cpu_rdata_12ef", CPU_RDATA, 16'h12EF);

        // Both requesters held: four video words per CPU word, 4-cycle period.
        VID_ADDR = 20'h00040; CPU_ADDR = 20'h00041; CPU_WE = 1'b0; CPU_BE = 2'b11;
        VID_REQ = 1'b1; CPU_REQ = 1'b1;
        order = '0;
        last  = 0;
        for (int k = 0; k < 10; k++) begin
            got = 1'b0;
            for (int w = 0; w < 8 && !got; w++) begin
                @(negedge CLK);
                got = VID_GNT | CPU_GNT;
            end
            check("arb_gnt_seen", got, 1);
            if (!got) break;
            check("arb_single_gnt", VID_GNT & CPU_GNT, 0);
            if (CPU_GNT) begin
                order[k] = 1'b1;
                cpu_sb.push_back('{1'b1, exp_word(20'h00041)});
            end else begin
                vid_sb.push_back('{1'b1, exp_word(20'h00040)});
            end
            if (k > 0) check("arb_period", cyc - last, 4);
            last = cyc;
            if (k == 9) begin
                VID_REQ = 1'b0;
                CPU_REQ = 1'b0;
            end
        end
        check("arb_order", order, 10'h210);
        drain();

        // Reset while lane 0 of a write is strobing.
        CPU_ADDR = 20'h00030; CPU_WE = 1'b1; CPU_BE = 2'b11; CPU_WDATA = 16'hCAFE;
        CPU_REQ = 1'b1;
        wait_gnt(1'b1, ok);
        check("abort_gnt_seen", ok, 1);
        CPU_REQ = 1'b0;
        @(negedge CLK);
        check("abort_pre_we_n", SRAM_WE_n, 0);
        RST_n = 1'b0;
        #1;
        check_rst("abort");
        cpu_gc.delete();
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        repeat (6) @(negedge CLK);
        check("abort_mem_untouched", {mem[8'h61], mem[8'h60]}, exp_word(20'h00030));

        // A clean access after the aborted one.
        cpu_write_pins(20'h00031, 16'hA55A, 2'b01);
        vid_read(20'h00031);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_word_arbiter.md
# sram_word_arbiter

Shares the single 8-bit asynchronous 2 MB board SRAM between two 16-bit requesters: the video fetch path and the CPU/bus path. Each granted access is a 16-bit word. It is sequenced as two byte cycles, with the even byte first. The block sits between the system core and the top-level SRAM pins. Only the tristate buffer on the data bus lives outside it, at the top level.

## Interface
Parameters:
- ADDR_W, 20, word-address width; SRAM byte address is ADDR_W+1 bits.
- MAX_VID_RUN, 4, maximum number of consecutive video grants while a CPU request is pending.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - CLK  in  1  system clock.
  - RST_n  in  1  asynchronous active-low reset.
- Video requester (read only):
  - VID_REQ  in  1  video read request; held until VID_GNT.
  - VID_ADDR  in  ADDR_W  video word address.
  - VID_GNT  out  1  one-cycle pulse: video request accepted.
  - VID_DONE  out  1  one-cycle pulse: VID_RDATA valid.
  - VID_RDATA  out  16  read word.
- CPU requester:
  - CPU_REQ  in  1  CPU request; CPU_WE/BE/ADDR/WDATA are held stable until CPU_GNT.
  - CPU_WE  in  1  1 = write.
  - CPU_BE  in  2  byte enables; bit0 is the even byte (bits 7:0).
  - CPU_ADDR  in  ADDR_W  CPU word address.
  - CPU_WDATA  in  16  write word.
  - CPU_GNT  out  1  one-cycle accept pulse.
  - CPU_DONE  out  1  one-cycle completion pulse for both reads and writes.
  - CPU_RDATA  out  16  read word, valid with CPU_DONE.
- SRAM side:
  - SRAM_ADDR  out  ADDR_W+1  byte address, registered.
  - SRAM_WE_n  out  1  write strobe, registered.
  - SRAM_DQ_O  out  8  write data.
  - SRAM_DQ_OE  out  1  drive enable for the top-level tristate.
  - SRAM_DQ_I  in  8  read data from the pins.

## Operation
- Sequencer states: IDLE, L0A, L0B, L1A, L1B.
  - Lane 0 uses byte address {addr,0}; lane 1 uses {addr,1}.
  - "A" cycle: address and data driven, SRAM_WE_n high.
  - "B" cycle: SRAM_WE_n low only if the access is a write and BE for that lane is 1. SRAM_DQ_I is captured at the end of every B cycle.
- Transitions:
  - IDLE→L0A when any request is present.
  - L0A→L0B→L1A→L1B.
  - L1B→L0A if a request is present; otherwise L1B→IDLE.
  - Back-to-back accesses therefore cost exactly 4 cycles each.
- Disabled lane: a lane with BE=0 still consumes its A and B cycles, but the strobe stays high. Timing is fixed regardless of BE.
- SRAM_DQ_OE is 1 during the A and B cycles of an enabled write lane, and 0 otherwise.
- Arbitration is evaluated only in IDLE and L1B:
  - Video wins by default.
  - If vid_run == MAX_VID_RUN and CPU_REQ is 1, the CPU wins.
  - vid_run increments on each video grant, saturating at MAX_VID_RUN, and clears on each CPU grant.
  - When both requests arrive in the same cycle, this rule applies unchanged.
- The winner's address, WE, BE and WDATA are latched at the grant edge. Requesters may change their inputs after GNT.
- For video grants, WE is forced to 0.
- Reset values: SRAM_WE_n=1, SRAM_DQ_OE=0, SRAM_ADDR=0, SRAM_DQ_O=0, all GNT/DONE=0, both RDATA=0, vid_run=0, state=IDLE.
- Reset mid-access aborts the access: SRAM_WE_n goes high asynchronously and no DONE is issued for the aborted access.

## Timing
- Edge E0 samples the request. GNT is high E0–E1 (state L0A), L0B is E1–E2, L1A is E2–E3, L1B is E3–E4.
- DONE and RDATA are high/valid E4–E5.
  - RDATA holds its value until the next DONE for that requester.
- Sustained throughput is one word per 4 cycles. A new GNT may coincide with the previous DONE.
- All SRAM outputs come directly from flops; there is no combinational path from requests to the pins.
- Each lane has one full cycle of address setup before SRAM_WE_n falls.

## Structure
- Shared package `sram_arb_pkg`: state enum (IDLE, L0A, L0B, L1A, L1B), requester ID constants (REQ_VID, REQ_CPU), and the MAX_VID_RUN default.
- Sub-module `sram_arb_pick`: combinational winner selection plus the vid_run counter.
- The sequencer, datapath latches and read assembly stay in the top module.

## Test plan
- Reset: assert RST_n=0 mid-run → SRAM_WE_n=1, SRAM_DQ_OE=0, SRAM_ADDR=0, all GNT/DONE=0 within the same cycle.
- CPU write, CPU_ADDR=0x00012, WDATA=0xBEEF, BE=11 → addr 0x000024 with data 0xEF and WE_n low one cycle, then 0x000025 with 0xBE and WE_n low one cycle; CPU_DONE pulses at E4.
- CPU write, BE=10, WDATA=0x1234 → lane 0 has WE_n high and OE=0; lane 1 writes 0x12; DONE still at E4.
- Video read, VID_ADDR=0x00012, SRAM model bytes 0xEF/0xBE → VID_RDATA=0xBEEF with VID_DONE at E4.
- Both requests held continuously → grant order V,V,V,V,C,V,V,V,V,C; back-to-back access period is exactly 4 cycles.
- Reset asserted during L0B of a write, then released → WE_n rises immediately; no CPU_DONE; the next request starts cleanly from IDLE.
